// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth multiplier that retires one Booth digit per clock.
// It handles signed or unsigned operands through a start/done handshake.
// Optional feature: define BOOTH_EARLY_TERM_EN to finish as soon as every
// remaining multiplier digit is zero. The result is the same either way.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 clear,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned E_W   = WIDTH + 2;          // extended operand width
    localparam int unsigned ITER  = E_W / 2;            // Booth steps
    localparam int unsigned ACC_W = 2 * E_W;            // accumulator width
    localparam int unsigned Q_W   = E_W + 1;            // multiplier plus implicit bit
    localparam int unsigned K_W   = $clog2(ITER + 1);
    localparam int unsigned X_W   = E_W - WIDTH;
    localparam int unsigned MX_W  = ACC_W - WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_nxt;

    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   m_q;        // multiplicand, pre-shifted by 2k
    logic [Q_W-1:0]     q_q;        // multiplier, shifted right by 2k; bit 0 is q[2k-1]
    logic [K_W-1:0]     k_q;

    logic [ACC_W-1:0]   m_cap;
    logic [Q_W-1:0]     q_cap;
    logic [ACC_W-1:0]   pp;
    logic [ACC_W-1:0]   acc_step;
    logic [Q_W-1:0]     q_step;
    logic               rest_zero;
    logic               last_step;
    logic               capture;
    logic               busy_nxt;
    logic               done_nxt;

    // Operand extension at capture: the sign bit is repeated only for signed operands.
    always_comb begin
        m_cap = {{MX_W{is_signed & multiplicand[WIDTH-1]}}, multiplicand};
        q_cap = {{X_W{is_signed & multiplier[WIDTH-1]}}, multiplier, 1'b0};
    end

    // Booth digit decode from the current bit triple.
    always_comb begin
        pp = '0;
        case (q_q[2:0])
            3'b001, 3'b010: pp = m_q;
            3'b011:         pp = m_q << 1;
            3'b100:         pp = -(m_q << 1);
            3'b101, 3'b110: pp = -m_q;
            default:        pp = '0;
        endcase
    end

    // Results of one step. The shift is arithmetic so the remaining bits stay sign-consistent.
    always_comb begin
        acc_step = acc_q + pp;
        q_step   = {{2{q_q[Q_W-1]}}, q_q[Q_W-1:2]};
    end

    // After a step, the remaining digits are all zero when the bits left are uniform.
`ifdef BOOTH_EARLY_TERM_EN
    always_comb begin
        rest_zero = (q_step == '0) || (&q_step);
    end
`else
    always_comb begin
        rest_zero = 1'b0;
    end
`endif

    // Final step detection: either the last digit or no nonzero digits remain.
    always_comb begin
        last_step = (k_q == K_W'(ITER - 1)) || rest_zero;
    end

    // State register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic. A start request is accepted in IDLE and in DONE.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last_step) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output and control decode. The busy and done values are one cycle ahead of the registers.
    always_comb begin
        capture  = 1'b0;
        busy_nxt = 1'b0;
        done_nxt = 1'b0;
        capture  = start && (state_q != S_RUN);
        busy_nxt = (state_nxt == S_RUN);
        done_nxt = (state_nxt == S_DONE);
    end

    // Registered handshake outputs.
    always_ff @(posedge clock) begin
        if (clear) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt;
            done <= done_nxt;
        end
    end

    // Datapath: capture the operands, run one Booth step per cycle, and load the product on the last step.
    always_ff @(posedge clock) begin
        if (clear) begin
            acc_q   <= '0;
            m_q     <= '0;
            q_q     <= '0;
            k_q     <= '0;
            product <= '0;
        end else if (capture) begin
            acc_q <= '0;
            m_q   <= m_cap;
            q_q   <= q_cap;
            k_q   <= '0;
        end else if (state_q == S_RUN) begin
            acc_q <= acc_step;
            m_q   <= m_q << 2;
            q_q   <= q_step;
            k_q   <= k_q + K_W'(1);
            if (last_step) begin
                product <= acc_step[2*WIDTH-1:0];
            end
        end
    end

endmodule

// File: doc/booth_mul_seq.md
# booth_mul_seq

Sequential, parametrised radix-4 Booth multiplier with a start/done handshake. It handles signed or unsigned operands and retires one Booth digit per clock. It replaces the combinational Booth multiplier in the ALU datapath, where the MUL instruction writes HI/LO from `product`. The control unit holds the instruction in its execute step until `done` is asserted.

## Interface
- `WIDTH`, default 32: operand width. Must be even and ≥ 4.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `clear`  in  1  reset, synchronous and active-high.
- `start`  in  1  request a multiply. Sampled only while `busy`=0.
- `is_signed`  in  1  1 = two's-complement operands, 0 = unsigned. Sampled with `start`.
- `multiplicand`  in  WIDTH  M. Sampled with `start`.
- `multiplier`  in  WIDTH  Q. Sampled with `start`.
- `busy`  out  1  high while in state RUN.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle onward.
- `product`  out  2*WIDTH  M×Q; held until the next accepted `start` completes.

## Operation
- **Internal widths.**
  - Operands are extended to E = WIDTH+2 bits: sign-extended when `is_signed`=1, zero-extended otherwise.
  - The step count is ITER = E/2 (17 for WIDTH=32).
  - The accumulator is at least 2*WIDTH+4 bits. `product` is its low 2*WIDTH bits.
- **Booth digits.** Each step examines the triple {q[2k+1], q[2k], q[2k−1]}, with q[−1]=0 (implicit bit).
  - 000 or 111 → 0
  - 001 or 010 → +M
  - 011 → +2M
  - 100 → −2M
  - 101 or 110 → −M
  - The digit's partial product, shifted left by 2k, is added to the accumulator. All arithmetic is modulo 2^(width of the accumulator).
- **States.**
  - IDLE: `start`=1 captures the operands, clears the accumulator, sets k=0 and moves to RUN.
  - RUN: one step per cycle, k increments. After step ITER−1 (or on early exit, see Configuration), `product` is loaded, `done` is set and the state moves to DONE.
  - DONE: `done`=1 for this cycle only. `start`=1 here is accepted exactly as in IDLE (back-to-back operation); otherwise the next state is IDLE.
- `start` while in RUN is ignored. No queueing.
- `is_signed` and the operand inputs may change freely after the capture edge.
- **`clear`.** Takes priority over all other inputs in any state. It forces IDLE, `busy`=0, `done`=0, `product`=0 and the accumulator to 0. An in-flight operation is discarded and does not produce `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, state IDLE.
- `start` sampled high at edge E0 → `busy`=1 from E0.
- With fixed latency, `product` and `done` are registered at edge E0+ITER. For WIDTH=32, `done` is high in the cycle after edge E0+17, and `busy` falls at that same edge.
- Back-to-back: with `start`=1 during the `done` cycle, the next operation captures at that edge and `busy` is high again one cycle after it fell.
- Throughput without early exit: one result per ITER+1 cycles.
- `product` is stable from `done` until the next completion or `clear`.

## Configuration
- **`BOOTH_EARLY_TERM_EN` defined.**
  - After each step, the remaining multiplier bits {q[E−1] … q[2k+1]} (with q[2k+1] as the new implicit bit) are checked. If they are all 0 or all 1, every remaining digit is 0.
  - In that case the block loads `product`, pulses `done` and goes to DONE immediately.
  - Latency is 1 to ITER cycles. At least one step always executes.
- **Not defined.** There is no early-exit logic and latency is fixed at ITER.
- The result is identical in both configurations.

## Test plan
All scenarios use WIDTH=32.
- **Signed, small operands.** `is_signed`=1, M=−3 (0xFFFFFFFD), Q=7 → `product`=0xFFFFFFFF_FFFFFFEB; `done` 17 cycles after the start edge (early term off).
- **Unsigned, maximum operands.** `is_signed`=0, M=Q=0xFFFFFFFF → `product`=0xFFFFFFFE_00000001. With the same bit patterns and `is_signed`=1 → `product`=0x00000000_00000001.
- **Signed, most-negative operands.** `is_signed`=1, M=Q=0x80000000 → `product`=0x40000000_00000000. Then back-to-back with `start` held high in the `done` cycle: M=5, Q=−5 → `product`=0xFFFFFFFF_FFFFFFE7, with no idle cycle between the two operations.
- **Start while busy, then clear mid-operation.**
  - `start` pulsed again at cycle 5 of RUN with different operands → ignored; first result correct.
  - A new operation with `clear` asserted at cycle 8 → next cycle `busy`=0, `product`=0, and no `done` ever.
- **Early termination (`BOOTH_EARLY_TERM_EN`).**
  - Q=0 → `done` after 1 step, `product`=0.
  - Q=3, M=10 → `done` after 2 steps, `product`=30.
  - Q=0xFFFFFFFF signed, M=9 → `done` after 1 step, `product`=0xFFFFFFFF_FFFFFFF7.
- **Randomised cross-check.** 10 000 random M, Q and `is_signed` values checked against a reference multiply in both macro configurations.
